// File: rtl/parity_rx.sv
// -----------------------------------------------------------------------------
// parity_rx
// Serial frame receiver with parity and stop-bit checking. One line bit is
// consumed per in_valid strobe. A frame is: start (0), 8 data bits LSB first,
// parity bit, stop bit (1). Completed frames are presented with a
// valid/ready handshake; frames that land on an unconsumed result overwrite it
// and raise a sticky overrun flag.
//
// Parameters
//   PARITY_ODD  0 = even parity expected, 1 = odd parity expected
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    bit strobe; in_bit is only looked at when this is 1
//   in_bit      serial line value (idle level 1)
//   out_ready   consumer accepts data_out when data_valid && out_ready
//   clr_count   synchronous clear of err_count (wins over an increment)
//   data_out    last received data byte
//   data_valid  data_out holds an unconsumed frame
//   parity_err  parity mismatch on the frame in data_out
//   frame_err   stop bit was 0 on the frame in data_out
//   overrun     sticky: a frame completed while data_valid=1 and out_ready=0
//   err_count   saturating count of frames with a parity or frame error
//   busy        FSM is not in IDLE (registered)
// -----------------------------------------------------------------------------
module parity_rx #(
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_bit,
    input  logic       out_ready,
    input  logic       clr_count,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic [7:0] err_count,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic       acc_q, acc_d;
    logic [7:0] shift_q, shift_d;
    logic       perr_q, perr_d;      // parity result of the frame in flight

    logic [7:0] data_out_q, data_out_d;
    logic       data_valid_q, data_valid_d;
    logic       parity_err_q, parity_err_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;
    logic [7:0] err_count_q, err_count_d;
    logic       busy_q, busy_d;

    logic       complete;            // stop-bit strobe this cycle

    // Frame-assembly FSM.
    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        shift_d  = shift_q;
        perr_d   = perr_q;
        complete = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (!in_bit) begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                        acc_d   = 1'b0;
                    end
                end
                DATA: begin
                    shift_d[idx_q] = in_bit;
                    acc_d          = acc_q ^ in_bit;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    perr_d  = acc_q ^ in_bit ^ PARITY_ODD;
                    state_d = STOP;
                end
                STOP: begin
                    // The stop strobe always closes the frame; a 0 here is
                    // reported as a frame error rather than resynchronising.
                    complete = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output side: result registers, handshake, overrun and error counter.
    always_comb begin
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
        err_count_d  = err_count_q;

        if (complete) begin
            data_out_d   = shift_q;
            parity_err_d = perr_q;
            frame_err_d  = ~in_bit;
            data_valid_d = 1'b1;
            // A coincident accepting handshake consumes the old frame, so
            // only an unaccepted pending frame counts as lost.
            if (data_valid_q && !out_ready) begin
                overrun_d = 1'b1;
            end
        end else if (data_valid_q && out_ready) begin
            data_valid_d = 1'b0;
        end

        if (clr_count) begin
            err_count_d = 8'd0;
        end else if (complete && (perr_q || !in_bit) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end

        busy_d = (state_d != IDLE);
    end

    // NOTE: all state, including the data shift register, is reset so that a
    // mid-frame reset leaves nothing of the partial frame behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= 3'd0;
            acc_q        <= 1'b0;
            shift_q      <= 8'h00;
            perr_q       <= 1'b0;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            err_count_q  <= 8'd0;
            busy_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values computed by the combinational blocks.
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            err_count_q  <= err_count_d;
            busy_q       <= busy_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign err_count  = err_count_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_parity_rx.sv
// -----------------------------------------------------------------------------
// tb_parity_rx
// Directed bench for parity_rx. An even-parity and an odd-parity instance
// share the same stimulus; expected values are hand-computed per frame.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_parity_rx;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_bit;
    logic       out_ready;
    logic       clr_count;

    logic [7:0] e_data_out, o_data_out;
    logic       e_data_valid, o_data_valid;
    logic       e_parity_err, o_parity_err;
    logic       e_frame_err, o_frame_err;
    logic       e_overrun, o_overrun;
    logic [7:0] e_err_count, o_err_count;
    logic       e_busy, o_busy;

    int n_checks = 0;
    int n_pass   = 0;

    parity_rx #(.PARITY_ODD(1'b0)) u_even (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .out_ready  (out_ready),
        .clr_count  (clr_count),
        .data_out   (e_data_out),
        .data_valid (e_data_valid),
        .parity_err (e_parity_err),
        .frame_err  (e_frame_err),
        .overrun    (e_overrun),
        .err_count  (e_err_count),
        .busy       (e_busy)
    );

    parity_rx #(.PARITY_ODD(1'b1)) u_odd (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .out_ready  (out_ready),
        .clr_count  (clr_count),
        .data_out   (o_data_out),
        .data_valid (o_data_valid),
        .parity_err (o_parity_err),
        .frame_err  (o_frame_err),
        .overrun    (o_overrun),
        .err_count  (o_err_count),
        .busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One strobe, held for one clock, followed by an idle cycle.
    task automatic send_bit(input logic b, input logic clr);
        @(negedge clk);
        in_valid  = 1'b1;
        in_bit    = b;
        clr_count = clr;
        @(negedge clk);
        in_valid  = 1'b0;
        in_bit    = 1'b1;
        clr_count = 1'b0;
    endtask

    // Returns on the falling edge after the stop strobe, when results are visible.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input logic clr_on_stop);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
        send_bit(p, 1'b0);
        send_bit(s, clr_on_stop);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b1;
        out_ready = 1'b1;
        clr_count = 1'b0;

        // Reset state
        #12;
        check("rst data_out",   {24'd0, e_data_out}, 32'h00);
        check("rst data_valid", {31'd0, e_data_valid}, 32'd0);
        check("rst parity_err", {31'd0, e_parity_err}, 32'd0);
        check("rst frame_err",  {31'd0, e_frame_err}, 32'd0);
        check("rst overrun",    {31'd0, e_overrun}, 32'd0);
        check("rst err_count",  {24'd0, e_err_count}, 32'd0);
        check("rst busy",       {31'd0, e_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle-level strobes are ignored
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check("idle ones busy", {31'd0, e_busy}, 32'd0);

        // 0xA5, parity 0, stop 1: clean for even, parity error for odd
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        check("a5 data_out",    {24'd0, e_data_out}, 32'hA5);
        check("a5 data_valid",  {31'd0, e_data_valid}, 32'd1);
        check("a5 parity_err",  {31'd0, e_parity_err}, 32'd0);
        check("a5 frame_err",   {31'd0, e_frame_err}, 32'd0);
        check("a5 err_count",   {24'd0, e_err_count}, 32'd0);
        check("a5 busy",        {31'd0, e_busy}, 32'd0);
        check("a5 odd perr",    {31'd0, o_parity_err}, 32'd1);
        check("a5 odd count",   {24'd0, o_err_count}, 32'd1);
        @(negedge clk);
        check("a5 dv pulse",    {31'd0, e_data_valid}, 32'd0);

        // 0xA5, parity 1: error for even, clean for odd
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        check("a5p1 parity_err", {31'd0, e_parity_err}, 32'd1);
        check("a5p1 err_count",  {24'd0, e_err_count}, 32'd1);
        check("a5p1 odd perr",   {31'd0, o_parity_err}, 32'd0);
        check("a5p1 odd count",  {24'd0, o_err_count}, 32'd1);

        // 0x3C, parity 0, stop 0: frame error
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check("3c data_out",   {24'd0, e_data_out}, 32'h3C);
        check("3c frame_err",  {31'd0, e_frame_err}, 32'd1);
        check("3c parity_err", {31'd0, e_parity_err}, 32'd0);
        check("3c err_count",  {24'd0, e_err_count}, 32'd2);
        check("3c busy",       {31'd0, e_busy}, 32'd0);
        check("3c odd count",  {24'd0, o_err_count}, 32'd2);

        // Reset mid-frame after 4 data bits
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);  // leave a valid result pending
        out_ready = 1'b0;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        check("mid busy", {31'd0, e_busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst data_out",   {24'd0, e_data_out}, 32'h00);
        check("mid rst data_valid", {31'd0, e_data_valid}, 32'd0);
        check("mid rst err_count",  {24'd0, e_err_count}, 32'd0);
        check("mid rst busy",       {31'd0, e_busy}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        check("post rst data_out",   {24'd0, e_data_out}, 32'h3C);
        check("post rst parity_err", {31'd0, e_parity_err}, 32'd0);
        check("post rst frame_err",  {31'd0, e_frame_err}, 32'd0);
        check("post rst err_count",  {24'd0, e_err_count}, 32'd0);
        check("post rst odd count",  {24'd0, o_err_count}, 32'd1);
        @(negedge clk);

        // Overrun: two frames with out_ready held low
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        check("ovr first overrun", {31'd0, e_overrun}, 32'd0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("ovr data_out",   {24'd0, e_data_out}, 32'h22);
        check("ovr data_valid", {31'd0, e_data_valid}, 32'd1);
        check("ovr overrun",    {31'd0, e_overrun}, 32'd1);
        check("ovr odd count",  {24'd0, o_err_count}, 32'd3);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("ovr accepted dv",   {31'd0, e_data_valid}, 32'd0);
        check("ovr sticky",        {31'd0, e_overrun}, 32'd1);
        out_ready = 1'b1;

        // Saturation: 300 bad-parity frames for the even instance
        for (int n = 0; n < 300; n++) send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        check("sat err_count",  {24'd0, e_err_count}, 32'd255);
        check("sat odd count",  {24'd0, o_err_count}, 32'd3);
        check("sat overrun",    {31'd0, e_overrun}, 32'd1);

        // Clear coincident with a bad-frame completion
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        check("clr err_count",     {24'd0, e_err_count}, 32'd0);
        check("clr odd count",     {24'd0, o_err_count}, 32'd0);
        check("clr parity_err",    {31'd0, e_parity_err}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/parity_rx.md
PARITY_RX -- requirements
Module: parity_rx

Interface
REQ-001 Parameter: PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  bit strobe; in_bit sampled only on cycles where in_valid=1.
REQ-005 in_bit  input  1  serial line value; idle level 1.
REQ-006 out_ready  input  1  consumer accepts data_out when data_valid=1 and out_ready=1.
REQ-007 clr_count  input  1  synchronous clear of err_count.
REQ-008 data_out  output  8  last received data byte.
REQ-009 data_valid  output  1  data_out holds an unconsumed frame.
REQ-010 parity_err  output  1  parity mismatch on the frame in data_out.
REQ-011 frame_err  output  1  stop bit sampled as 0 on the frame in data_out.
REQ-012 overrun  output  1  sticky; a frame completed while data_valid=1 and out_ready=0.
REQ-013 err_count  output  8  count of frames with parity_err or frame_err, saturating.
REQ-014 busy  output  1  1 when the FSM is in any state other than IDLE.

Function
REQ-015 The frame format SHALL be: start bit 0, 8 data bits LSB first, 1 parity bit, stop bit 1; exactly one bit per in_valid strobe.
REQ-016 The FSM SHALL have states IDLE, DATA, PARITY and STOP; only in_valid=1 cycles advance it.
REQ-017 IDLE: in_bit=0 -> DATA, with the bit index and the XOR accumulator cleared; in_bit=1 -> stay in IDLE, ignored.
REQ-018 DATA: each strobe SHALL shift in_bit into bit position index and XOR it into the accumulator; after bit index 7 -> PARITY.
REQ-019 PARITY: parity error SHALL be computed as (accumulator XOR in_bit XOR PARITY_ODD) != 0 and latched internally -> STOP.
REQ-020 STOP: the strobe SHALL complete the frame regardless of in_bit value; in_bit=0 sets frame error; -> IDLE.
REQ-021 On the cycle after the STOP strobe, the block SHALL assert data_valid=1 and update data_out, parity_err and frame_err together (1-cycle latency).
REQ-022 data_valid SHALL remain 1, with data_out, parity_err and frame_err stable, until a cycle with out_ready=1; it clears on the following edge.
REQ-023 A frame completing while data_valid=1 and out_ready=0 SHALL overwrite data_out, parity_err and frame_err, keep data_valid=1, and set overrun.
REQ-024 Completion coincident with an accepting handshake (data_valid=1, out_ready=1) SHALL load the new frame with data_valid=1 and SHALL NOT set overrun.
REQ-025 overrun SHALL clear only on reset.
REQ-026 err_count SHALL increment by 1 per completed frame with a parity or frame error, saturating at 255 with no wrap.
REQ-027 clr_count=1 SHALL set err_count to 0 on the next edge, and SHALL win over a simultaneous increment.
REQ-028 in_valid=0 cycles SHALL leave all state unchanged, except for handshake and clr_count effects.
REQ-029 busy SHALL be registered, reflecting the FSM state.

Reset
REQ-030 While rst_n=0, regardless of clk: FSM=IDLE, bit index=0, accumulator=0, data_out=8'h00, data_valid=0, parity_err=0, frame_err=0, overrun=0, err_count=0, busy=0.
REQ-031 Reset mid-frame SHALL discard the partial frame; the first strobe after release is treated as an IDLE-state sample.

Verification
REQ-032 Even mode: frame 0,1,0,1,0,0,1,0,1,0,1 (0xA5, parity 0, stop 1), out_ready=1 -> data_out=0xA5, data_valid pulses for 1 cycle, parity_err=0, frame_err=0, err_count=0.
REQ-033 Even mode: 0xA5 with parity bit 1 -> parity_err=1, err_count=1; same frame with PARITY_ODD=1 -> parity_err=0.
REQ-034 Stop bit 0 on 0x3C, parity 0 -> data_out=0x3C, frame_err=1, err_count increments, FSM back in IDLE with busy=0.
REQ-035 rst_n pulsed low after 4 data bits -> all outputs 0 immediately; the next full 0x3C frame is received cleanly.
REQ-036 out_ready=0, frames 0x11 then 0x22 -> data_out=0x22, data_valid=1, overrun=1; out_ready=1 for one cycle -> data_valid=0, overrun stays 1.
REQ-037 300 bad-parity frames -> err_count=255; clr_count=1 coincident with a bad frame completion -> err_count=0.
